// File: rtl/frame_loader.sv
// frame_loader
//   Turns a UART byte stream into pixel writes for a frame buffer. A frame
//   starts with the SYNC byte. It is followed by W*H pixels of two bytes each,
//   high byte first. Pixels are written linearly into the current write buffer.
//   An XOR check code is produced for every BLK_PIX pixels, with a possibly
//   short final block. On a complete frame the display buffer index is swapped.
//
// Ports
//   i_clk_sys      system clock
//   i_rst          synchronous active-high reset
//   i_enable       allows new frames to start (gates SYNC detection only)
//   i_rx_data      received UART byte
//   i_rx_valid     one-cycle strobe qualifying i_rx_data
//   i_abort        one-cycle request to drop the frame in progress
//   o_wr_en        one-cycle pixel write strobe
//   o_wr_addr      buffer base + pixel index
//   o_wr_data      packed pixel
//   o_check_code   XOR of every byte of the finished block
//   o_check_valid  one-cycle strobe for o_check_code
//   o_busy         frame in progress
//   o_frame_done   one-cycle pulse after the last pixel of a frame
//   o_err          one-cycle pulse when a frame is dropped (timeout / abort)
//   o_disp_buf     buffer index the display side should read
//   o_pix_cnt      pixels written in the current frame

module frame_loader #(
  parameter int         W           = 50,
  parameter int         H           = 40,
  parameter int         PIX_BITS    = 12,
  parameter int         ADDR_W      = 15,
  parameter int         NUM_BUF     = 2,
  parameter int         BLK_PIX     = 50,
  parameter logic [7:0] SYNC        = 8'hA5,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic                i_clk_sys,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_abort,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [PIX_BITS-1:0] o_wr_data,
  output logic [7:0]          o_check_code,
  output logic                o_check_valid,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_err,
  output logic                o_disp_buf,
  output logic [ADDR_W-1:0]   o_pix_cnt
);

  localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(W * H);
  localparam int                BLK_W     = $clog2(BLK_PIX + 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLK_PIX - 1);
  localparam int                TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  // Only the bits of the high byte that end up in the pixel are kept
  localparam int                HI_BITS   = PIX_BITS - 8;
  localparam logic              WBUF_INIT = (NUM_BUF == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIX_HI,
    S_PIX_LO,
    S_CHK,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [HI_BITS-1:0]   hi_q;
  logic [7:0]           xor_q;
  logic [BLK_W-1:0]     blk_cnt_q;
  logic [TMO_W-1:0]     tmo_cnt_q;
  logic                 wbuf_q;

  logic timeout_hit, abort_req, frame_full, last_pix, blk_full;
  logic start_frame, take_hi, write_pix, fire_chk, fire_done;

  // Frame-level conditions shared by the next-state and output decode.
  // A byte arriving on the timeout edge itself resets the idle count, so it wins.
  always_comb begin
    timeout_hit = ((state_q == S_PIX_HI) || (state_q == S_PIX_LO)) &&
                  !i_rx_valid && (tmo_cnt_q == TMO_LAST);
    abort_req   = (state_q != S_IDLE) && (i_abort || timeout_hit);
    frame_full  = (o_pix_cnt == FRAME_PIX);
    last_pix    = (o_pix_cnt == FRAME_PIX - ADDR_W'(1));
    blk_full    = (blk_cnt_q == BLK_LAST);
  end

  // State register
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. CHK still accepts a high byte so nothing is lost
  // during its single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_enable && i_rx_valid && (i_rx_data == SYNC)) state_d = S_PIX_HI;
      S_PIX_HI: if (i_rx_valid) state_d = S_PIX_LO;
      S_PIX_LO: if (i_rx_valid) state_d = (blk_full || last_pix) ? S_CHK : S_PIX_HI;
      S_CHK: begin
        if (frame_full)      state_d = S_DONE;
        else if (i_rx_valid) state_d = S_PIX_LO;
        else                 state_d = S_PIX_HI;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_req) state_d = S_IDLE;
  end

  // Output/event decode. An abort suppresses every other action that cycle.
  always_comb begin
    start_frame = (state_q == S_IDLE) && i_enable && i_rx_valid && (i_rx_data == SYNC);
    take_hi     = !abort_req && i_rx_valid &&
                  ((state_q == S_PIX_HI) || ((state_q == S_CHK) && !frame_full));
    write_pix   = !abort_req && i_rx_valid && (state_q == S_PIX_LO);
    fire_chk    = !abort_req && (state_q == S_CHK);
    fire_done   = !abort_req && (state_q == S_DONE);
    o_busy      = (state_q == S_PIX_HI) || (state_q == S_PIX_LO) || (state_q == S_CHK);
  end

  // Datapath and registered strobes
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_check_code  <= '0;
      o_check_valid <= 1'b0;
      o_frame_done  <= 1'b0;
      o_err         <= 1'b0;
      o_disp_buf    <= 1'b0;
      o_pix_cnt     <= '0;
      hi_q          <= '0;
      xor_q         <= '0;
      blk_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      wbuf_q        <= WBUF_INIT;
    end else begin
      o_wr_en       <= write_pix;
      o_check_valid <= fire_chk;
      o_frame_done  <= fire_done;
      o_err         <= abort_req;

      if (take_hi) hi_q <= i_rx_data[HI_BITS-1:0];

      if (write_pix) begin
        o_wr_addr <= (wbuf_q ? FRAME_PIX : '0) + o_pix_cnt;
        o_wr_data <= {hi_q, i_rx_data};
      end

      if (abort_req || start_frame)
        o_pix_cnt <= '0;
      else if (write_pix)
        o_pix_cnt <= o_pix_cnt + ADDR_W'(1);

      // Block counter wraps on a full block and on the short final block
      if (abort_req || start_frame)
        blk_cnt_q <= '0;
      else if (write_pix)
        blk_cnt_q <= (blk_full || last_pix) ? '0 : blk_cnt_q + BLK_W'(1);

      // In CHK the finished code is handed out and accumulation restarts,
      // seeded with any high byte arriving in the same cycle
      if (abort_req || start_frame)
        xor_q <= '0;
      else if (fire_chk)
        xor_q <= take_hi ? i_rx_data : 8'h00;
      else if (take_hi || write_pix)
        xor_q <= xor_q ^ i_rx_data;

      if (fire_chk) o_check_code <= xor_q;

      if ((state_q == S_IDLE) || i_rx_valid || abort_req)
        tmo_cnt_q <= '0;
      else
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);

      if (fire_done && (NUM_BUF == 2)) begin
        o_disp_buf <= wbuf_q;
        wbuf_q     <= ~wbuf_q;
      end
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader
//   Drives random and directed UART byte streams into two frame_loader
//   instances sharing one input stream: a 12-bit ping-pong instance and a
//   16-bit single-buffer instance. Writes, check codes and pulses are
//   captured and compared with a reference model built from the frame rules.

module tb_frame_loader;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int BLK  = 4;
  localparam int AW   = 5;
  localparam int TMO  = 100;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable, rx_valid, abort;
  logic [7:0] rx_data;

  logic          wr_en, chk_v, busy, done, err, disp;
  logic [AW-1:0] wr_addr, pix_cnt;
  logic [11:0]   wr_data;
  logic [7:0]    chk_code;

  logic          wr_en16, chk_v16, busy16, done16, err16, disp16;
  logic [AW-1:0] wr_addr16, pix_cnt16;
  logic [15:0]   wr_data16;
  logic [7:0]    chk_code16;

  frame_loader #(.W(W), .H(H), .PIX_BITS(12), .ADDR_W(AW), .NUM_BUF(2),
                 .BLK_PIX(BLK), .SYNC(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .i_clk_sys(clk), .i_rst(rst), .i_enable(enable), .i_rx_data(rx_data),
    .i_rx_valid(rx_valid), .i_abort(abort), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_check_code(chk_code), .o_check_valid(chk_v),
    .o_busy(busy), .o_frame_done(done), .o_err(err), .o_disp_buf(disp),
    .o_pix_cnt(pix_cnt));

  frame_loader #(.W(W), .H(H), .PIX_BITS(16), .ADDR_W(AW), .NUM_BUF(1),
                 .BLK_PIX(BLK), .SYNC(8'hA5), .TIMEOUT_CYC(TMO)) dut16 (
    .i_clk_sys(clk), .i_rst(rst), .i_enable(enable), .i_rx_data(rx_data),
    .i_rx_valid(rx_valid), .i_abort(abort), .o_wr_en(wr_en16), .o_wr_addr(wr_addr16),
    .o_wr_data(wr_data16), .o_check_code(chk_code16), .o_check_valid(chk_v16),
    .o_busy(busy16), .o_frame_done(done16), .o_err(err16), .o_disp_buf(disp16),
    .o_pix_cnt(pix_cnt16));

  int n_checks = 0;
  int n_errors = 0;

  // Pixel byte pairs of the frame being sent
  logic [7:0] hi_q[$];
  logic [7:0] lo_q[$];

  // Captured DUT activity
  logic [AW-1:0] seen_addr[$];
  logic [AW-1:0] seen_addr16[$];
  logic [11:0]   seen_data[$];
  logic [15:0]   seen_data16[$];
  logic [7:0]    seen_chk[$];
  logic [7:0]    seen_chk16[$];
  int seen_done, seen_done16, seen_err, seen_err16;

  // Reference buffer state
  int exp_wbuf, exp_disp;

  // Capture outputs mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (wr_en)   begin seen_addr.push_back(wr_addr);     seen_data.push_back(wr_data);     end
    if (wr_en16) begin seen_addr16.push_back(wr_addr16); seen_data16.push_back(wr_data16); end
    if (chk_v)   seen_chk.push_back(chk_code);
    if (chk_v16) seen_chk16.push_back(chk_code16);
    if (done)    seen_done++;
    if (done16)  seen_done16++;
    if (err)     seen_err++;
    if (err16)   seen_err16++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got timeout exp completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gap(input int g);
    if (g <= 0) idle($urandom_range(1, 4));
    else        idle(g);
  endtask

  task automatic clear_seen();
    seen_addr.delete(); seen_addr16.delete();
    seen_data.delete(); seen_data16.delete();
    seen_chk.delete();  seen_chk16.delete();
    seen_done = 0; seen_done16 = 0; seen_err = 0; seen_err16 = 0;
  endtask

  task automatic random_pixels();
    hi_q.delete(); lo_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      hi_q.push_back(8'($urandom));
      lo_q.push_back(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom));
    end
  endtask

  task automatic send_pixels(input int first, input int count, input int g);
    for (int i = first; i < first + count; i++) begin
      send_byte(hi_q[i]); gap(g);
      send_byte(lo_q[i]); gap(g);
    end
  endtask

  task automatic send_frame(input int g, input int tail);
    send_byte(8'hA5); gap(g);
    send_pixels(0, NPIX, g);
    idle(tail);
  endtask

  // Compares one completed frame against the model and advances the buffers
  task automatic check_frame(input string tag);
    int         base;
    logic [7:0] x;
    logic [7:0] exp_chk[$];
    base = exp_wbuf * NPIX;
    x = 8'h00;
    for (int i = 0; i < NPIX; i++) begin
      x = x ^ hi_q[i] ^ lo_q[i];
      if (((i + 1) % BLK == 0) || (i == NPIX - 1)) begin
        exp_chk.push_back(x);
        x = 8'h00;
      end
    end
    n_checks++;
    if (seen_addr.size() !== NPIX || seen_addr16.size() !== NPIX) begin
      n_errors++;
      $display("[TB] FAIL %s write_count got %0d/%0d exp %0d", tag,
               seen_addr.size(), seen_addr16.size(), NPIX);
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        n_checks++;
        if (seen_addr[i] !== AW'(base + i)) begin
          n_errors++;
          $display("[TB] FAIL %s addr[%0d] got %0d exp %0d", tag, i, seen_addr[i], base + i);
        end
        n_checks++;
        if (seen_data[i] !== 12'((hi_q[i] & 8'h0F) * 256 + lo_q[i])) begin
          n_errors++;
          $display("[TB] FAIL %s data12[%0d] got %h exp %h", tag, i, seen_data[i],
                   12'((hi_q[i] & 8'h0F) * 256 + lo_q[i]));
        end
        n_checks++;
        if (seen_data16[i] !== 16'(hi_q[i] * 256 + lo_q[i]) || seen_addr16[i] !== AW'(i)) begin
          n_errors++;
          $display("[TB] FAIL %s pix16[%0d] got %h@%0d exp %h@%0d", tag, i, seen_data16[i],
                   seen_addr16[i], 16'(hi_q[i] * 256 + lo_q[i]), i);
        end
      end
    end
    n_checks++;
    if (seen_chk.size() !== exp_chk.size() || seen_chk16.size() !== exp_chk.size()) begin
      n_errors++;
      $display("[TB] FAIL %s check_count got %0d/%0d exp %0d", tag, seen_chk.size(),
               seen_chk16.size(), exp_chk.size());
    end else begin
      for (int b = 0; b < exp_chk.size(); b++) begin
        n_checks++;
        if (seen_chk[b] !== exp_chk[b] || seen_chk16[b] !== exp_chk[b]) begin
          n_errors++;
          $display("[TB] FAIL %s check_code[%0d] got %h/%h exp %h", tag, b, seen_chk[b],
                   seen_chk16[b], exp_chk[b]);
        end
      end
    end
    exp_disp = exp_wbuf;
    exp_wbuf = 1 - exp_wbuf;
    n_checks++;
    if (seen_done !== 1 || seen_done16 !== 1 || seen_err !== 0) begin
      n_errors++;
      $display("[TB] FAIL %s pulses got done=%0d done16=%0d err=%0d exp 1 1 0", tag,
               seen_done, seen_done16, seen_err);
    end
    n_checks++;
    if (disp !== exp_disp[0] || disp16 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL %s disp_buf got %b/%b exp %0d/0", tag, disp, disp16, exp_disp);
    end
    n_checks++;
    if (pix_cnt !== AW'(NPIX) || busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL %s end_state got cnt=%0d busy=%b exp cnt=%0d busy=0", tag,
               pix_cnt, busy, NPIX);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; rx_valid = 1'b0; abort = 1'b0; rx_data = 8'h00;
    idle(3);
    n_checks++;
    if ({wr_en, chk_v, busy, done, err, disp} !== 6'b0 || pix_cnt !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_flags got %b cnt=%0d exp 000000 cnt=0",
               {wr_en, chk_v, busy, done, err, disp}, pix_cnt);
    end
    n_checks++;
    if (wr_addr !== '0 || wr_data !== '0 || chk_code !== 8'h00 || wr_data16 !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_data got addr=%0d data=%h chk=%h d16=%h exp zeros",
               wr_addr, wr_data, chk_code, wr_data16);
    end
    rst = 1'b0;
    idle(2);
    exp_wbuf = 1; exp_disp = 0;
    clear_seen();
  endtask

  task automatic test_spec_frames();
    logic [7:0] first_chk[$];
    hi_q.delete(); lo_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      hi_q.push_back(8'h0F);
      lo_q.push_back(8'(i));
    end
    clear_seen();
    send_frame(3, 6);
    check_frame("spec_frame1");
    first_chk = seen_chk;
    clear_seen();
    send_frame(3, 6);
    check_frame("spec_frame2");
    n_checks++;
    if (seen_chk !== first_chk) begin
      n_errors++;
      $display("[TB] FAIL spec_repeat_codes got %p exp %p", seen_chk, first_chk);
    end
  endtask

  task automatic test_packing();
    random_pixels();
    hi_q[0] = 8'hF1;
    lo_q[0] = 8'h23;
    clear_seen();
    send_frame(0, 6);
    n_checks++;
    if (seen_data.size() == 0 || seen_data[0] !== 12'h123 || seen_data16[0] !== 16'hF123) begin
      n_errors++;
      $display("[TB] FAIL packing got %h/%h exp 123/f123",
               (seen_data.size() > 0) ? seen_data[0] : 12'hx,
               (seen_data16.size() > 0) ? seen_data16[0] : 16'hx);
    end
    check_frame("packing");
  endtask

  task automatic test_random_frames(input int n);
    for (int f = 0; f < n; f++) begin
      random_pixels();
      clear_seen();
      // Stray bytes before SYNC must be ignored
      for (int j = 0; j < 3; j++) begin
        logic [7:0] junk;
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk); gap(0);
      end
      send_frame(0, 6);
      check_frame($sformatf("random%0d", f));
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      random_pixels();
      clear_seen();
      send_frame(1, 3);
      check_frame($sformatf("b2b%0d", f));
    end
  endtask

  task automatic test_timeout();
    int hit;
    random_pixels();
    clear_seen();
    send_byte(8'hA5); gap(2);
    send_pixels(0, 2, 2);
    send_byte(hi_q[2]); gap(2);
    send_byte(lo_q[2]);
    hit = 0;
    for (int k = 1; k <= 2 * TMO; k++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        hit = k;
        break;
      end
    end
    n_checks++;
    if (hit != TMO) begin
      n_errors++;
      $display("[TB] FAIL timeout_cycle got %0d exp %0d", hit, TMO);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || pix_cnt !== '0 || busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL timeout_after got err=%b cnt=%0d busy=%b exp 0 0 0", err, pix_cnt, busy);
    end
    idle(3);
    n_checks++;
    if (seen_addr.size() !== 3 || seen_done !== 0 || seen_err !== 1 || disp !== exp_disp[0]) begin
      n_errors++;
      $display("[TB] FAIL timeout_summary got wr=%0d done=%0d err=%0d disp=%b exp 3 0 1 %0d",
               seen_addr.size(), seen_done, seen_err, disp, exp_disp);
    end
  endtask

  task automatic test_abort();
    random_pixels();
    clear_seen();
    send_byte(8'hA5); gap(2);
    send_pixels(0, 2, 2);
    send_byte(hi_q[2]); gap(2);
    @(negedge clk);
    rx_data = lo_q[2]; rx_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; abort = 1'b0;
    n_checks++;
    if (err !== 1'b1 || wr_en !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL abort_pulse got err=%b wr_en=%b exp 1 0", err, wr_en);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0 || pix_cnt !== '0) begin
      n_errors++;
      $display("[TB] FAIL abort_after got err=%b busy=%b cnt=%0d exp 0 0 0", err, busy, pix_cnt);
    end
    for (int j = 0; j < 4; j++) begin
      send_byte(8'h10 + 8'(j)); gap(2);
    end
    // Abort while idle must be ignored
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    idle(3);
    n_checks++;
    if (seen_addr.size() !== 2 || busy !== 1'b0 || seen_err !== 1 || seen_err16 !== 1) begin
      n_errors++;
      $display("[TB] FAIL abort_summary got wr=%0d busy=%b err=%0d/%0d exp 2 0 1/1",
               seen_addr.size(), busy, seen_err, seen_err16);
    end
  endtask

  task automatic test_enable();
    random_pixels();
    clear_seen();
    enable = 1'b0;
    send_byte(8'hA5); gap(2);
    send_pixels(0, 2, 2);
    n_checks++;
    if (seen_addr.size() !== 0 || busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL enable_low_idle got wr=%0d busy=%b exp 0 0", seen_addr.size(), busy);
    end
    enable = 1'b1;
    clear_seen();
    send_byte(8'hA5); gap(2);
    enable = 1'b0;
    send_pixels(0, NPIX, 0);
    idle(6);
    enable = 1'b1;
    check_frame("enable_mid_frame");
  endtask

  task automatic test_reset_midframe();
    random_pixels();
    clear_seen();
    send_byte(8'hA5); gap(2);
    send_pixels(0, 5, 2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++;
    if (disp !== 1'b0 || pix_cnt !== '0 || busy !== 1'b0 || seen_err !== 0) begin
      n_errors++;
      $display("[TB] FAIL midframe_reset got disp=%b cnt=%0d busy=%b err=%0d exp 0 0 0 0",
               disp, pix_cnt, busy, seen_err);
    end
    exp_wbuf = 1; exp_disp = 0;
    random_pixels();
    clear_seen();
    send_frame(0, 6);
    check_frame("after_reset");
  endtask

  initial begin
    test_reset();
    test_spec_frames();
    test_packing();
    test_random_frames(3);
    test_back_to_back();
    test_timeout();
    test_abort();
    test_enable();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
